// File: rtl/tof_mod_meas.sv
// ToF modulation meter: measures MODIN period/high time and the delay from the VALID rise to the first MODIN rise.
// Optional TOFMEAS_INSYNC_EN adds a 2-flop MODIN synchronizer (DELAY_MEAS +2, period/high unchanged).
module tof_mod_meas #(
  parameter int CNT_W    = 16,
  parameter int LOCK_CNT = 4
) (
  input  logic             CLKIN,
  input  logic             RST,
  input  logic             VALID,
  input  logic             MODIN,
  output logic [CNT_W-1:0] PERIOD_MEAS,
  output logic [CNT_W-1:0] HIGH_MEAS,
  output logic [CNT_W-1:0] DELAY_MEAS,
  output logic             MEAS_STB,
  output logic             LOCKED,
  output logic             ERR
);

  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] LOCK_TGT = CNT_W'(LOCK_CNT);

  typedef enum logic [1:0] {IDLE, WAIT_FIRST, MEASURE} state_t;

  state_t           state;
  logic             mod_s;
  logic             mod_d;
  logic             valid_d;
  logic [CNT_W-1:0] dly_cnt;
  logic [CNT_W-1:0] per_cnt;
  logic [CNT_W-1:0] hi_lat;
  logic [CNT_W-1:0] match_cnt;

`ifdef TOFMEAS_INSYNC_EN
  logic [1:0] sync;
  always_ff @(posedge CLKIN) begin
    if (RST) sync <= 2'b00;
    else     sync <= {sync[0], MODIN};
  end
  assign mod_s = sync[1];
`else
  assign mod_s = MODIN;
`endif

  logic             rise;
  logic             fall;
  logic             vrise;
  logic [CNT_W-1:0] dly_nxt;
  logic [CNT_W-1:0] per_nxt;
  logic [CNT_W-1:0] match_nxt;

  assign rise    = mod_s & ~mod_d;
  assign fall    = ~mod_s & mod_d;
  assign vrise   = VALID & ~valid_d;
  // Counters report "cycles elapsed including this one", so the restart cycle is 0.
  assign dly_nxt = (dly_cnt == CNT_MAX) ? CNT_MAX : dly_cnt + CNT_W'(1);
  assign per_nxt = (per_cnt == CNT_MAX) ? CNT_MAX : per_cnt + CNT_W'(1);
  // A zero match count means no reference period yet in this VALID window.
  assign match_nxt = (match_cnt != '0 && per_nxt == PERIOD_MEAS)
                   ? ((match_cnt >= LOCK_TGT) ? match_cnt : match_cnt + CNT_W'(1))
                   : CNT_W'(1);

  always_ff @(posedge CLKIN) begin
    if (RST) begin
      state       <= IDLE;
      mod_d       <= 1'b0;
      valid_d     <= 1'b1;
      dly_cnt     <= '0;
      per_cnt     <= '0;
      hi_lat      <= '0;
      match_cnt   <= '0;
      PERIOD_MEAS <= '0;
      HIGH_MEAS   <= '0;
      DELAY_MEAS  <= '0;
      MEAS_STB    <= 1'b0;
      LOCKED      <= 1'b0;
      ERR         <= 1'b0;
    end else begin
      mod_d    <= mod_s;
      valid_d  <= VALID;
      MEAS_STB <= 1'b0;
      if (!VALID) begin
        state     <= IDLE;
        LOCKED    <= 1'b0;
        match_cnt <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (vrise) begin
              ERR       <= 1'b0;
              dly_cnt   <= '0;
              per_cnt   <= '0;
              match_cnt <= '0;
              if (rise) begin
                DELAY_MEAS <= '0;
                state      <= MEASURE;
              end else begin
                state <= WAIT_FIRST;
              end
            end
          end
          WAIT_FIRST: begin
            if (rise) begin
              DELAY_MEAS <= dly_nxt;
              per_cnt    <= '0;
              state      <= MEASURE;
            end else if (dly_nxt == CNT_MAX) begin
              ERR    <= 1'b1;
              LOCKED <= 1'b0;
              state  <= IDLE;
            end else begin
              dly_cnt <= dly_nxt;
            end
          end
          MEASURE: begin
            if (rise) begin
              PERIOD_MEAS <= per_nxt;
              HIGH_MEAS   <= hi_lat;
              MEAS_STB    <= 1'b1;
              per_cnt     <= '0;
              match_cnt   <= match_nxt;
              LOCKED      <= (match_nxt >= LOCK_TGT);
            end else if (per_nxt == CNT_MAX) begin
              ERR       <= 1'b1;
              LOCKED    <= 1'b0;
              match_cnt <= '0;
              state     <= IDLE;
            end else begin
              per_cnt <= per_nxt;
              if (fall) hi_lat <= per_nxt;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_tof_mod_meas.sv
// Directed bench for tof_mod_meas; expected values hand-derived, LAT accounts for the optional MODIN synchronizer.
module tb_tof_mod_meas;

`ifdef TOFMEAS_INSYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  localparam int RISES   [8] = '{5, 15, 25, 35, 45, 55, 66, 76};
  localparam int EXP_PER [7] = '{10, 10, 10, 10, 10, 11, 10};
  localparam int EXP_LCK [7] = '{0, 0, 0, 1, 1, 0, 0};

  logic CLKIN = 1'b0;
  logic RST, VALID, MODIN, valid8, modin8;
  logic [15:0] period_meas, high_meas, delay_meas;
  logic        meas_stb, locked, err;
  logic [7:0]  p8, h8, d8;
  logic        stb8, lk8, err8;

  int n_vec = 0;
  int n_err = 0;

  always #5 CLKIN = ~CLKIN;

  tof_mod_meas u_dut (
    .CLKIN(CLKIN), .RST(RST), .VALID(VALID), .MODIN(MODIN),
    .PERIOD_MEAS(period_meas), .HIGH_MEAS(high_meas), .DELAY_MEAS(delay_meas),
    .MEAS_STB(meas_stb), .LOCKED(locked), .ERR(err)
  );

  tof_mod_meas #(.CNT_W(8)) u_sat (
    .CLKIN(CLKIN), .RST(RST), .VALID(valid8), .MODIN(modin8),
    .PERIOD_MEAS(p8), .HIGH_MEAS(h8), .DELAY_MEAS(d8),
    .MEAS_STB(stb8), .LOCKED(lk8), .ERR(err8)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge CLKIN);
    #1;
  endtask

  function automatic logic wave1(input int k);
    for (int i = 0; i < 8; i++)
      if (k >= RISES[i] && k < RISES[i] + 5) return 1'b1;
    return 1'b0;
  endfunction

  initial begin
    RST = 1'b1; VALID = 1'b0; MODIN = 1'b0; valid8 = 1'b0; modin8 = 1'b0;
    repeat (3) step();
    chk("rst_period", 32'(period_meas), 0);
    chk("rst_high",   32'(high_meas),   0);
    chk("rst_delay",  32'(delay_meas),  0);
    chk("rst_stb",    32'(meas_stb),    0);
    chk("rst_locked", 32'(locked),      0);
    chk("rst_err",    32'(err),         0);
    RST = 1'b0;
    repeat (2) step();

    // Square wave 10/5, first rise at t0+5, then one 11-cycle period.
    for (int k = 0; k < 85; k++) begin
      int idx;
      VALID = 1'b1;
      MODIN = wave1(k);
      step();
      idx = -1;
      for (int i = 1; i < 8; i++)
        if (k - LAT == RISES[i]) idx = i - 1;
      chk("sq_stb", 32'(meas_stb), (idx >= 0) ? 1 : 0);
      if (idx >= 0) begin
        chk("sq_period", 32'(period_meas), EXP_PER[idx]);
        chk("sq_high",   32'(high_meas),   5);
        chk("sq_locked", 32'(locked),      EXP_LCK[idx]);
      end
      if (k == 4 + LAT) chk("sq_delay_pre", 32'(delay_meas), 0);
      if (k == 5 + LAT) chk("sq_delay",     32'(delay_meas), 5 + LAT);
    end

    // MODIN already high at VALID rise; falls at +3, rises at +7, next rise at +19 coincides with VALID fall.
    VALID = 1'b0;
    MODIN = 1'b1;
    repeat (4) step();
    chk("idle_locked", 32'(locked),      0);
    chk("idle_period", 32'(period_meas), 10);
    for (int k = 0; k < 22; k++) begin
      VALID = (k < 19 + LAT) ? 1'b1 : 1'b0;
      MODIN = (k < 3) ? 1'b1 : (k < 7) ? 1'b0 : (k < 12) ? 1'b1 : (k < 19) ? 1'b0 : 1'b1;
      step();
      chk("hi_stb", 32'(meas_stb), 0);
      if (k == 6 + LAT) chk("hi_delay_pre", 32'(delay_meas), 5 + LAT);
      if (k == 7 + LAT) chk("hi_delay",     32'(delay_meas), 7 + LAT);
    end
    chk("vfall_period", 32'(period_meas), 10);

    // MODIN rises on the same cycle VALID is first sampled high.
    VALID = 1'b0;
    MODIN = 1'b0;
    repeat (3) step();
    for (int k = 0; k < 34; k++) begin
      VALID = (k < 27) ? 1'b1 : 1'b0;
      MODIN = ((k % 10) < 5) ? 1'b1 : 1'b0;
      step();
      if (k == LAT) chk("same_delay", 32'(delay_meas), LAT);
      if (k == 10 + LAT) begin
        chk("same_stb",    32'(meas_stb),    1);
        chk("same_period", 32'(period_meas), 10);
      end
      if (k >= 27) chk("drop_stb", 32'(meas_stb), 0);
    end
    RST = 1'b1;
    repeat (2) step();
    chk("rst2_period", 32'(period_meas), 0);
    chk("rst2_high",   32'(high_meas),   0);
    chk("rst2_delay",  32'(delay_meas),  0);
    chk("rst2_stb",    32'(meas_stb),    0);
    chk("rst2_locked", 32'(locked),      0);
    chk("rst2_err",    32'(err),         0);

    // VALID held high across reset release must not arm a measurement.
    VALID = 1'b1;
    RST = 1'b0;
    for (int k = 0; k < 40; k++) begin
      MODIN = ((k % 10) >= 3 && (k % 10) < 8) ? 1'b1 : 1'b0;
      step();
      chk("norearm_stb", 32'(meas_stb), 0);
    end
    chk("norearm_period", 32'(period_meas), 0);
    chk("norearm_delay",  32'(delay_meas),  0);

    // 8-bit instance: MODIN held low saturates the delay counter.
    for (int k = 0; k < 261; k++) begin
      valid8 = 1'b1;
      modin8 = (k >= 258) ? 1'b1 : 1'b0;
      step();
      if (k == 254) chk("sat_err_pre", 32'(err8), 0);
      if (k == 255) chk("sat_err",     32'(err8), 1);
      if (k >= 256) chk("sat_stb",     32'(stb8), 0);
    end
    chk("sat_delay_hold", 32'(d8), 0);
    valid8 = 1'b0;
    modin8 = 1'b0;
    step();
    chk("sat_err_hold", 32'(err8), 1);
    valid8 = 1'b1;
    step();
    chk("sat_err_clr", 32'(err8), 0);
    for (int k = 1; k < 7; k++) begin
      modin8 = (k >= 4) ? 1'b1 : 1'b0;
      step();
      if (k == 4 + LAT) chk("sat_rearm_delay", 32'(d8), 4 + LAT);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/tof_mod_meas.md
TOF_MOD_MEAS -- requirements
Module: tof_mod_meas

Interface
REQ-001 Parameter CNT_W, default 16, width of all cycle counters and measurement outputs.
REQ-002 Parameter LOCK_CNT, default 4, number of consecutive identical periods required for lock.
REQ-003 CLKIN  input  1  sole clock; all logic rising-edge triggered.
REQ-004 RST  input  1  synchronous, active-high reset.
REQ-005 VALID  input  1  measurement enable; its rising sample is the delay reference instant t0.
REQ-006 MODIN  input  1  modulation waveform under test (ToF modulation clock), sampled on CLKIN.
REQ-007 PERIOD_MEAS  output  CNT_W  cycles between the last two MODIN rising edges.
REQ-008 HIGH_MEAS  output  CNT_W  cycles MODIN was high in the last completed period.
REQ-009 DELAY_MEAS  output  CNT_W  cycles from t0 to the first MODIN rising edge.
REQ-010 MEAS_STB  output  1  one-cycle pulse when PERIOD_MEAS/HIGH_MEAS update.
REQ-011 LOCKED  output  1  high while the last LOCK_CNT periods were identical.
REQ-012 ERR  output  1  sticky timeout flag.

Function
REQ-013 Edge detect: mod_d register tracks the sampled MODIN every cycle, including IDLE; rise = MODIN & ~mod_d, fall = ~MODIN & mod_d.
REQ-014 A MODIN already high when VALID rises is not a rise; the block waits for the next true 0->1 transition.
REQ-015 FSM states: IDLE, WAIT_FIRST, MEASURE; reset state IDLE.
REQ-016 IDLE -> WAIT_FIRST when VALID sampled 1 with previous sample 0; delay counter cleared to 0 on that cycle.
REQ-017 WAIT_FIRST: delay counter increments once per cycle; on rise, DELAY_MEAS <= counter value (t1 - t0), period counter restarts, -> MEASURE.
REQ-018 Rise on the same cycle VALID first samples high: DELAY_MEAS = 0, -> MEASURE.
REQ-019 MEASURE: period and high counters increment each cycle; high counter latched at fall; on rise, PERIOD_MEAS <= cycles since previous rise, HIGH_MEAS <= latched high count, counters restart.
REQ-020 MEAS_STB asserts exactly one cycle after the rise that completes a period; no pulse for the first rise.
REQ-021 Period match counter increments when new period equals previous PERIOD_MEAS, else resets to 1; LOCKED = (match count >= LOCK_CNT), updated with MEAS_STB.
REQ-022 All counters saturate at 2^CNT_W-1; reaching saturation in WAIT_FIRST or MEASURE sets ERR, clears LOCKED, returns FSM to IDLE-wait (no re-arm until VALID falls and rises again).
REQ-023 VALID low in any state -> IDLE next cycle; LOCKED and match count cleared; PERIOD_MEAS, HIGH_MEAS, DELAY_MEAS retain last values; ERR cleared on next VALID rise.
REQ-024 VALID fall and MODIN rise on the same cycle: VALID takes priority, no update, no MEAS_STB.

Reset
REQ-025 RST high: FSM IDLE, all counters, PERIOD_MEAS, HIGH_MEAS, DELAY_MEAS = 0, MEAS_STB, LOCKED, ERR = 0, mod_d = 0.
REQ-026 RST asserted mid-measurement aborts with no MEAS_STB; after RST release a high VALID is not a rise (previous-sample register cleared to 1-equivalent: requires VALID low then high).

Configuration
REQ-027 Macro TOFMEAS_INSYNC_EN defined: MODIN passes a 2-flop synchronizer before edge detection; DELAY_MEAS increases by exactly 2; PERIOD_MEAS and HIGH_MEAS unchanged.
REQ-028 Macro undefined: MODIN used directly (caller guarantees CLKIN-synchronous input); no added latency.

Verification
REQ-029 VALID rises at t0, MODIN square wave period 10, high 5, first rise at t0+5 -> DELAY_MEAS=5, PERIOD_MEAS=10, HIGH_MEAS=5, MEAS_STB every 10 cycles.
REQ-030 Same stimulus, 4th matching period -> LOCKED=1 coincident with MEAS_STB; one period of 11 -> LOCKED=0, PERIOD_MEAS=11.
REQ-031 MODIN high when VALID rises, falls at +3, rises at +7 -> DELAY_MEAS=7, no earlier update.
REQ-032 CNT_W=8, VALID high, MODIN held low -> ERR=1 after 255 cycles, FSM idle; VALID toggle -> ERR=0, measurement restarts.
REQ-033 VALID drops mid-period then RST pulse -> no MEAS_STB, all outputs 0 after RST.
REQ-034 TOFMEAS_INSYNC_EN defined, stimulus of REQ-029 -> DELAY_MEAS=7, PERIOD_MEAS=10, HIGH_MEAS=5.
